// File: rtl/bcd_gray_word_seq.sv
// Packed BCD word to packed Gray word, one digit per clock through one shared converter.
// Optional build macro BCD_GRAY_ABORT_ON_INVALID_EN: stop at the first invalid digit and fill the rest with 4'b1111.
module bcd_gray_word_seq #(
  parameter int DIGITS = 4,
  parameter int IDXW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   gray_word,
  output logic                  err,
  output logic [IDXW-1:0]       err_idx,
  output logic [7:0]            bad_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  logic [1:0]            state_reg, state_next;
  logic [IDXW-1:0]       idx_reg, idx_next;
  logic [4*DIGITS-1:0]   word_reg, word_next;
  logic [4*DIGITS-1:0]   gray_reg, gray_next;
  logic                  err_reg, err_next;
  logic [IDXW-1:0]       err_idx_reg, err_idx_next;
  logic [7:0]            bad_cnt_reg, bad_cnt_next;

  logic [3:0] cur_digit;
  logic [3:0] cur_gray;
  logic       cur_bad;
  logic       conv_en;
  logic       first_bad;

  // Shared digit converter: 0..9 to reflected Gray, A..F flagged as 4'b1111.
  function automatic logic [3:0] bcd_to_gray(input logic [3:0] d);
    if (d > 4'd9) begin
      return 4'b1111;
    end
    return d ^ {1'b0, d[3:1]};
  endfunction

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign conv_en   = (state_reg == ST_CONV);

  always_comb begin
    cur_digit = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_reg == IDXW'(k)) begin
        cur_digit = word_reg[4*k +: 4];
      end
    end
  end

  assign cur_gray  = bcd_to_gray(cur_digit);
  assign cur_bad   = (cur_digit > 4'd9);
  assign first_bad = conv_en && cur_bad && !err_reg;

  // Each result nibble is written only in the cycle its digit is converted (or filled on abort).
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib
      logic hit;
      logic fill;
      assign hit = conv_en && (idx_reg == IDXW'(gi));
`ifdef BCD_GRAY_ABORT_ON_INVALID_EN
      assign fill = first_bad && (idx_reg < IDXW'(gi));
`else
      assign fill = 1'b0;
`endif
      assign gray_next[4*gi +: 4] = hit  ? cur_gray :
                                    fill ? 4'b1111  :
                                           gray_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    word_next    = word_reg;
    err_next     = err_reg;
    err_idx_next = err_idx_reg;
    bad_cnt_next = bad_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          word_next    = bcd_word;
          idx_next     = '0;
          err_next     = 1'b0;
          err_idx_next = '0;
          state_next   = ST_CONV;
        end
      end
      ST_CONV: begin
        if (first_bad) begin
          err_next     = 1'b1;
          err_idx_next = idx_reg;
        end
        if (idx_reg == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          idx_next = idx_reg + IDXW'(1);
        end
`ifdef BCD_GRAY_ABORT_ON_INVALID_EN
        if (first_bad) begin
          state_next = ST_DONE;
        end
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
          if (err_reg && (bad_cnt_reg != 8'hFF)) begin
            bad_cnt_next = bad_cnt_reg + 8'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      word_reg    <= '0;
      gray_reg    <= '0;
      err_reg     <= 1'b0;
      err_idx_reg <= '0;
      bad_cnt_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      word_reg    <= word_next;
      gray_reg    <= gray_next;
      err_reg     <= err_next;
      err_idx_reg <= err_idx_next;
      bad_cnt_reg <= bad_cnt_next;
    end
  end

  assign gray_word = gray_reg;
  assign err       = err_reg;
  assign err_idx   = err_idx_reg;
  assign bad_cnt   = bad_cnt_reg;

endmodule

// File: doc/bcd_gray_word_seq.md
Name: bcd_gray_word_seq

Overview:
- Sequencing controller that converts a multi-digit packed BCD word to a packed Gray word, one digit per clock, through a single shared 4-bit BCD-to-Gray converter.
- Digit conversion follows the team's standard table: 0..9 map to binary-reflected Gray; codes A..F are invalid and produce 4'b1111.
- Sits between a BCD producer and a Gray consumer, with valid/ready handshakes on both sides.
- Reports the first invalid digit and keeps a saturating count of words that contained invalid digits.

Parameters:
- DIGITS, 4, number of BCD digits per word; legal range 2..8.
- IDXW, 3, width of the digit index; must satisfy 2**IDXW >= DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  producer has a word on bcd_word.
- in_ready  output  1  block can accept a word; high only in IDLE.
- bcd_word  input  4*DIGITS  packed BCD; digit k is bits [4k+3:4k].
- out_valid  output  1  gray_word, err and err_idx are valid.
- out_ready  input  1  consumer accepts the result.
- gray_word  output  4*DIGITS  packed Gray result; digit k is at the same position as in bcd_word.
- err  output  1  at least one invalid digit in the current result.
- err_idx  output  IDXW  index of the lowest-numbered invalid digit; 0 when err=0.
- bad_cnt  output  8  saturating count of completed words with err=1.

Behaviour:
- Interface decisions: one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
- Reset (asynchronous, rst_n low):
  - state=IDLE, in_ready=1, out_valid=0, gray_word=0, err=0, err_idx=0, bad_cnt=0.
  - Digit index and latched word are cleared.
  - Reset mid-conversion discards the word; no partial result is ever presented.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1 (combinational decode of state).
  - When in_valid&&in_ready at a clock edge: latch bcd_word, clear idx, err and err_idx, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle: convert digit idx and write the result nibble into gray_word[4*idx+3:4*idx].
  - If the digit is > 9: write 4'b1111; if err is not yet set, set err=1 and err_idx=idx.
  - When idx==DIGITS-1, go to DONE; otherwise idx increments.
- DONE:
  - out_valid=1; gray_word, err and err_idx are held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE, out_valid=0, and bad_cnt increments if err=1 (saturates at 255).
  - gray_word keeps its value after the transfer; it is not cleared.
- Latency:
  - Acceptance happens at edge 0; out_valid rises at edge DIGITS.
  - Minimum initiation interval is DIGITS+2 cycles (no overlap; in_ready is low in CONV and DONE).
- Backpressure: out_ready low in DONE holds the result indefinitely; in_valid is ignored outside IDLE.
- Simultaneous events: out_ready and in_valid are never both effective in the same cycle, because in_ready is only high in IDLE.
- Converter: combinational, 4-bit. Digit d (0..9) maps to d ^ (d>>1); any other code maps to 4'b1111.

Optional Feature:
- Macro: BCD_GRAY_ABORT_ON_INVALID_EN.
- Defined:
  - In CONV, the cycle that converts the first invalid digit also fills every unprocessed higher digit with 4'b1111 and goes directly to DONE.
  - out_valid therefore rises at edge err_idx+1 after acceptance.
  - err and err_idx behave as usual.
- Not defined: all DIGITS digits are always converted; latency is fixed at DIGITS.

Test Plan (DIGITS=4):
- Reset, then bcd_word=16'h1239, in_valid=1, out_ready=1 -> out_valid at edge 4, gray_word=16'h132D, err=0, err_idx=0, bad_cnt=0, in_ready back high the next cycle.
- bcd_word=16'h12A4 with macro undefined -> gray_word=16'h13F6, err=1, err_idx=1, out_valid at edge 4, bad_cnt=1 after transfer.
- Same 16'h12A4 with BCD_GRAY_ABORT_ON_INVALID_EN defined -> out_valid at edge 2, gray_word=16'hFFF6, err=1, err_idx=1.
- bcd_word=16'hB0C0 -> gray_word=16'hF0F0, err=1, err_idx=1 (first invalid digit, not the highest).
- Hold out_ready=0 for 10 cycles in DONE with in_valid=1 and a new word driven -> out_valid and gray_word stable, in_ready=0, new word not accepted; raising out_ready returns to IDLE, then the new word is accepted.
- Pulse rst_n low at edge 2 of a conversion -> out_valid, err and gray_word go to 0 immediately; after release, a new 16'h0987 converts to 16'h0DC4 normally.
- Drive 256 invalid words -> bad_cnt saturates at 255.
